sample_framer: RTL and testbench

Collects a continuous stream of audio ADC samples into N-sample frames and hands each complete frame to the 16-point radix-4 FFT stage directly downstream. Ping-pong banking keeps the presented frame stable for the FFT's whole computation while the next frame fills. The block drives the FFT's `time_samples` array and its one-cycle `start` pulse, and consumes its `done` pulse.

---
 rtl/audio_pkg.sv | 8 +
 rtl/sample_bank.sv | 32 +++
 rtl/sample_framer.sv | 106 ++++++++++
 tb/tb_sample_framer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types: default frame geometry and the sample / frame-index types.
package audio_pkg;
  localparam int WIDTH = 12;
  localparam int N     = 16;

  typedef logic [WIDTH-1:0]       sample_t;
  typedef logic [$clog2(N)-1:0]   frame_idx_t;
endpackage

// File: rtl/sample_bank.sv
// N-entry sample register file: one write port, full parallel read, async reset.
module sample_bank
  import audio_pkg::*;
#(
  parameter int WIDTH = audio_pkg::WIDTH,
  parameter int N     = audio_pkg::N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] idx,
  input  logic [WIDTH-1:0]     data,
  output logic [WIDTH-1:0]     q [N]
);
  logic [WIDTH-1:0] mem_q [N];
  logic [WIDTH-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign q = mem_q;
endmodule

// File: rtl/sample_framer.sv
// Ping-pong framer feeding the FFT; launch one cycle after the Nth sample (or on fft_done if busy).
// No input backpressure: samples arriving while a frame is pending are dropped and flag overrun.
// SAMPLE_FRAMER_OFFSET_BINARY_EN: convert offset-binary input to two's complement on write.
module sample_framer
  import audio_pkg::*;
#(
  parameter int WIDTH = audio_pkg::WIDTH,
  parameter int N     = audio_pkg::N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             fft_done,
  output logic             start,
  output logic [WIDTH-1:0] time_samples [0:N-1],
  output logic             fft_busy,
  output logic             overrun
);
  localparam int IW = $clog2(N);

  logic          wr_bank_q, wr_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          full_q, full_d;
  logic          fft_busy_q, fft_busy_d;
  logic          start_q, start_d;
  logic          overrun_q, overrun_d;

  logic             launch, accept, tgt_bank;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] bank0_q [N];
  logic [WIDTH-1:0] bank1_q [N];

`ifdef SAMPLE_FRAMER_OFFSET_BINARY_EN
  assign wr_data = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
`else
  assign wr_data = sample_in;
`endif

  // A launch frees the presented bank in the same edge, so a coincident sample lands there.
  assign launch   = full_q && (!fft_busy_q || fft_done);
  assign accept   = sample_valid && (!full_q || launch);
  assign tgt_bank = launch ? ~wr_bank_q : wr_bank_q;

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    full_d     = full_q;
    fft_busy_d = fft_busy_q;
    start_d    = launch;
    overrun_d  = overrun_q | (sample_valid && full_q && !launch);
    if (accept) wr_idx_d = wr_idx_q + 1'b1;
    if (launch) begin
      wr_bank_d  = ~wr_bank_q;
      full_d     = 1'b0;
      fft_busy_d = 1'b1;
    end else begin
      if (accept && wr_idx_q == IW'(N - 1)) full_d = 1'b1;
      if (fft_done) fft_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= 1'b0;
      fft_busy_q <= 1'b0;
      start_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_q     <= full_d;
      fft_busy_q <= fft_busy_d;
      start_q    <= start_d;
      overrun_q  <= overrun_d;
    end
  end

  sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank0 (
    .clk (clk),
    .rst (rst),
    .we  (accept && !tgt_bank),
    .idx (wr_idx_q),
    .data(wr_data),
    .q   (bank0_q)
  );

  sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank1 (
    .clk (clk),
    .rst (rst),
    .we  (accept && tgt_bank),
    .idx (wr_idx_q),
    .data(wr_data),
    .q   (bank1_q)
  );

  always_comb begin
    for (int i = 0; i < N; i++) time_samples[i] = wr_bank_q ? bank0_q[i] : bank1_q[i];
  end

  assign start    = start_q;
  assign fft_busy = fft_busy_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer: accepted samples queue up, each start pulse pops a frame.
module tb_sample_framer;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        fft_done = 1'b0;
  logic        start;
  logic [11:0] time_samples [0:15];
  logic        fft_busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  sample_t exp_q [$];

  always #5 clk = ~clk;

  sample_framer dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .fft_done    (fft_done),
    .start       (start),
    .time_samples(time_samples),
    .fft_busy    (fft_busy),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic sample_t xform(input sample_t v);
`ifdef SAMPLE_FRAMER_OFFSET_BINARY_EN
    return v ^ 12'h800;
`else
    return v;
`endif
  endfunction

  task automatic check_frame();
    if (exp_q.size() < 16) begin
      chk("frame_avail", exp_q.size(), 16);
    end else begin
      for (int i = 0; i < 16; i++) chk("frame", time_samples[i], exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (start) begin
      n_start++;
      check_frame();
    end
  endtask

  task automatic send(input sample_t v, input bit keep);
    sample_valid = 1'b1;
    sample_in    = v;
    if (keep) exp_q.push_back(xform(v));
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [11:0] ts_or;
    #12;
    chk("rst_start", start, 0);
    chk("rst_busy", fft_busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ts0", time_samples[0], 0);
    chk("rst_ts15", time_samples[15], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // first frame with idle FFT
    for (int i = 0; i < 16; i++) send(12'(i), 1'b1);
    chk("t1_no_early_start", start, 0);
    step();
    chk("t1_start", start, 1);
    chk("t1_busy", fft_busy, 1);
    step();
    chk("t1_start_pulse", start, 0);

    // second frame pending, launched by fft_done coincident with a valid sample
    for (int i = 16; i < 32; i++) send(12'(i), 1'b1);
    chk("t3_pending", start, 0);
    fft_done = 1'b1;
    send(12'h123, 1'b1);
    fft_done = 1'b0;
    chk("t3_start", start, 1);
    chk("t3_busy", fft_busy, 1);
    chk("t3_no_overrun", overrun, 0);

    // fill the next frame behind a busy FFT, then overflow by one
    for (int i = 1; i < 16; i++) send(12'h123 + 12'(i), 1'b1);
    send(12'h555, 1'b0);
    chk("t2_overrun", overrun, 1);
    chk("t2_no_start", start, 0);
    chk("t2_hold_ts0", time_samples[0], 32'(xform(12'd16)));
    chk("t2_hold_ts15", time_samples[15], 32'(xform(12'd31)));
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    chk("t2_start", start, 1);

    // async reset mid-frame
    for (int i = 0; i < 7; i++) send(12'h700 + 12'(i), 1'b0);
    rst = 1'b1;
    #1;
    ts_or = '0;
    for (int i = 0; i < 16; i++) ts_or |= time_samples[i];
    chk("t4_rst_start", start, 0);
    chk("t4_rst_busy", fft_busy, 0);
    chk("t4_rst_overrun", overrun, 0);
    chk("t4_rst_ts", ts_or, 0);
    rst = 1'b0;
    for (int i = 100; i < 116; i++) send(12'(i), 1'b1);
    step();
    chk("t4_start", start, 1);

    // code conversion
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    chk("t5_idle", fft_busy, 0);
    send(12'h800, 1'b1);
    send(12'h000, 1'b1);
    send(12'hFFF, 1'b1);
    for (int i = 3; i < 16; i++) send(12'(i), 1'b1);
    step();
    chk("t5_start", start, 1);
`ifdef SAMPLE_FRAMER_OFFSET_BINARY_EN
    chk("t5_ts0", time_samples[0], 32'h000);
    chk("t5_ts1", time_samples[1], 32'h800);
    chk("t5_ts2", time_samples[2], 32'h7FF);
`else
    chk("t5_ts0", time_samples[0], 32'h800);
    chk("t5_ts1", time_samples[1], 32'h000);
    chk("t5_ts2", time_samples[2], 32'hFFF);
`endif

    chk("start_count", n_start, 5);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
